// File: rtl/multicycle_ctrl.sv
// Multi-cycle main control FSM for the MIPS-subset datapath with a memory ready handshake and wait watchdog.
// Optional feature: define ILLEGAL_OP_TRAP_EN to trap on illegal opcodes instead of retiring them as NOPs.
module multicycle_ctrl #(
   parameter int WAIT_MAX = 15,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       op,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             ir_write,
   output logic             i_or_d,
   output logic             mem_read,
   output logic             mem_write,
   output logic             reg_write,
   output logic             reg_dst,
   output logic             mem_to_reg,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [2:0]       alu_op,
   output logic [1:0]       pc_src,
   output logic             instr_done,
   output logic [CNT_W-1:0] retired_cnt,
   output logic             mem_err,
   output logic [3:0]       state
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEM_ADDR = 4'd2,
      S_MEM_RD   = 4'd3,
      S_MEM_WB   = 4'd4,
      S_MEM_WR   = 4'd5,
      S_R_EXEC   = 4'd6,
      S_I_EXEC   = 4'd7,
      S_ALU_WB   = 4'd8,
      S_BRANCH   = 4'd9,
      S_JUMP     = 4'd10,
      S_TRAP     = 4'd11,
      S_HALT     = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam int WW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);
   localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_MAX - 1);

   state_t        st;
   logic [5:0]    op_q;
   logic [WW-1:0] wait_cnt;
   logic          is_wait;
   logic          op_legal;

   assign state    = st;
   assign is_wait  = (st == S_FETCH) || (st == S_MEM_RD) || (st == S_MEM_WR);
   assign op_legal = (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_SLTI) ||
                     (op == OP_ANDI)  || (op == OP_ORI)  || (op == OP_BEQ)  ||
                     (op == OP_LW)    || (op == OP_SW)   || (op == OP_J);

   always_ff @(posedge clk) begin
      if (rst) begin
         st          <= S_FETCH;
         op_q        <= '0;
         wait_cnt    <= '0;
         retired_cnt <= '0;
         mem_err     <= 1'b0;
      end else begin
         if (instr_done)
            retired_cnt <= retired_cnt + 1'b1;
         // The WAIT_MAX-th consecutive unanswered cycle trips the watchdog; a late ack on that cycle still wins.
         if (is_wait && !mem_ready) begin
            if (wait_cnt == WAIT_LAST) begin
               mem_err  <= 1'b1;
               st       <= S_HALT;
               wait_cnt <= '0;
            end else begin
               wait_cnt <= wait_cnt + 1'b1;
            end
         end else begin
            wait_cnt <= '0;
            case (st)
               S_FETCH:  st <= S_DECODE;
               S_DECODE: begin
                  op_q <= op;
                  case (op)
                     OP_RTYPE:                         st <= S_R_EXEC;
                     OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: st <= S_I_EXEC;
                     OP_BEQ:                           st <= S_BRANCH;
                     OP_LW, OP_SW:                     st <= S_MEM_ADDR;
                     OP_J:                             st <= S_JUMP;
`ifdef ILLEGAL_OP_TRAP_EN
                     default:                          st <= S_TRAP;
`else
                     default:                          st <= S_FETCH;
`endif
                  endcase
               end
               S_MEM_ADDR: st <= (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
               S_MEM_RD:   st <= S_MEM_WB;
               S_R_EXEC, S_I_EXEC: st <= S_ALU_WB;
               S_MEM_WB, S_MEM_WR, S_ALU_WB, S_BRANCH, S_JUMP: st <= S_FETCH;
               default:    st <= st;
            endcase
         end
      end
   end

   always_comb begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      i_or_d     = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = 3'b000;
      pc_src     = 2'b00;
      instr_done = 1'b0;
      if (!rst) begin
         case (st)
            S_FETCH: begin
               mem_read  = 1'b1;
               alu_src_b = 2'b01;
               ir_write  = mem_ready;
               pc_write  = mem_ready;
            end
            S_DECODE: begin
               alu_src_b = 2'b11;
`ifndef ILLEGAL_OP_TRAP_EN
               instr_done = !op_legal;
`endif
            end
            S_MEM_ADDR: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
            end
            S_MEM_RD: begin
               mem_read = 1'b1;
               i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
               reg_write  = 1'b1;
               mem_to_reg = 1'b1;
               instr_done = 1'b1;
            end
            S_MEM_WR: begin
               mem_write  = 1'b1;
               i_or_d     = 1'b1;
               instr_done = mem_ready;
            end
            S_R_EXEC: begin
               alu_src_a = 1'b1;
               alu_op    = 3'b100;
            end
            S_I_EXEC: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
               case (op_q)
                  OP_SLTI: alu_op = 3'b001;
                  OP_ANDI: alu_op = 3'b010;
                  OP_ORI:  alu_op = 3'b011;
                  default: alu_op = 3'b000;
               endcase
            end
            S_ALU_WB: begin
               reg_write  = 1'b1;
               reg_dst    = (op_q == OP_RTYPE);
               instr_done = 1'b1;
            end
            S_BRANCH: begin
               alu_src_a  = 1'b1;
               alu_op     = 3'b101;
               pc_src     = 2'b01;
               pc_write   = zero;
               instr_done = 1'b1;
            end
            S_JUMP: begin
               pc_src     = 2'b10;
               pc_write   = 1'b1;
               instr_done = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction transaction model with randomized memory latency.
module tb_multicycle_ctrl;
   localparam int WAIT_MAX = 15;

   logic        clk = 1'b0;
   logic        rst, zero, mem_ready;
   logic [5:0]  op;
   logic        pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write, reg_dst, mem_to_reg;
   logic        alu_src_a, instr_done, mem_err;
   logic [1:0]  alu_src_b, pc_src;
   logic [2:0]  alu_op;
   logic [31:0] retired_cnt;
   logic [3:0]  state;

   int errors = 0;
   int checks = 0;
   logic [31:0] model_retired = 0;

   multicycle_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
      .pc_write(pc_write), .ir_write(ir_write), .i_or_d(i_or_d), .mem_read(mem_read),
      .mem_write(mem_write), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
      .instr_done(instr_done), .retired_cnt(retired_cnt), .mem_err(mem_err), .state(state)
   );

   always #5 clk = ~clk;

   // 0 R, 1 I-type, 2 BEQ, 3 LW, 4 SW, 5 J, 6 illegal
   function automatic int kind_of(input logic [5:0] o);
      case (o)
         6'b000000: return 0;
         6'b001000, 6'b001010, 6'b001100, 6'b001101: return 1;
         6'b000100: return 2;
         6'b100011: return 3;
         6'b101011: return 4;
         6'b000010: return 5;
         default:   return 6;
      endcase
   endfunction

   task automatic do_reset();
      rst = 1'b1; op = '0; zero = 1'b0; mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      model_retired = 0;
   endtask

   task automatic run_instr(input logic [5:0] o, input logic z, input int fw, input int mw);
      int k, cyc, cnt, n_ir, n_pcw, n_rw, n_rd, n_wr;
      int e_cyc, e_rw, e_pcw, e_rd, e_wr;
      logic [1:0] last_pcsrc, e_pcsrc;
      logic [2:0] last_alu, e_alu;
      logic got_dst, got_m2r, done;
      k = kind_of(o);
      cyc = 0; cnt = fw; n_ir = 0; n_pcw = 0; n_rw = 0; n_rd = 0; n_wr = 0;
      last_pcsrc = 2'b00; last_alu = 3'b111; got_dst = 1'b0; got_m2r = 1'b0; done = 1'b0;
      op = o; zero = z;
      while (!done && cyc < 80) begin
         @(negedge clk);
         mem_ready = 1'b0;
         #1;
         if (mem_read || mem_write) mem_ready = (cnt == 0);
         #1;
         cyc++;
         if (ir_write) n_ir++;
         if (pc_write) begin n_pcw++; last_pcsrc = pc_src; end
         if (reg_write) begin n_rw++; got_dst = reg_dst; got_m2r = mem_to_reg; end
         if (mem_read) n_rd++;
         if (mem_write) n_wr++;
         if (alu_src_a) last_alu = alu_op;
         if (mem_read || mem_write) begin
            if (cnt == 0) cnt = mw; else cnt--;
         end
         if (instr_done) done = 1'b1;
      end
      case (k)
         0, 1: e_cyc = fw + 4;
         2, 5: e_cyc = fw + 3;
         3:    e_cyc = fw + mw + 5;
         4:    e_cyc = fw + mw + 4;
         default: e_cyc = fw + 2;
      endcase
      e_rw    = (k <= 1 || k == 3) ? 1 : 0;
      e_pcw   = 1 + ((k == 2 && z) ? 1 : 0) + ((k == 5) ? 1 : 0);
      e_pcsrc = (k == 2 && z) ? 2'b01 : (k == 5) ? 2'b10 : 2'b00;
      e_rd    = fw + 1 + ((k == 3) ? mw + 1 : 0);
      e_wr    = (k == 4) ? mw + 1 : 0;
      case (k)
         0: e_alu = 3'b100;
         1: e_alu = (o == 6'b001010) ? 3'b001 : (o == 6'b001100) ? 3'b010 :
                    (o == 6'b001101) ? 3'b011 : 3'b000;
         2: e_alu = 3'b101;
         3, 4: e_alu = 3'b000;
         default: e_alu = 3'b111;
      endcase
      checks++; if (cyc !== e_cyc) begin errors++; $display("FAIL cycles op=%b got %0d want %0d", o, cyc, e_cyc); end
      checks++; if (n_ir !== 1) begin errors++; $display("FAIL ir_write op=%b got %0d want 1", o, n_ir); end
      checks++; if (n_pcw !== e_pcw) begin errors++; $display("FAIL pc_write op=%b z=%b got %0d want %0d", o, z, n_pcw, e_pcw); end
      checks++; if (last_pcsrc !== e_pcsrc) begin errors++; $display("FAIL pc_src op=%b got %b want %b", o, last_pcsrc, e_pcsrc); end
      checks++; if (n_rw !== e_rw) begin errors++; $display("FAIL reg_write op=%b got %0d want %0d", o, n_rw, e_rw); end
      if (e_rw == 1) begin
         checks++; if (got_dst !== (k == 0)) begin errors++; $display("FAIL reg_dst op=%b got %b want %b", o, got_dst, (k == 0)); end
         checks++; if (got_m2r !== (k == 3)) begin errors++; $display("FAIL mem_to_reg op=%b got %b want %b", o, got_m2r, (k == 3)); end
      end
      checks++; if (n_rd !== e_rd) begin errors++; $display("FAIL mem_read_cycles op=%b got %0d want %0d", o, n_rd, e_rd); end
      checks++; if (n_wr !== e_wr) begin errors++; $display("FAIL mem_write_cycles op=%b got %0d want %0d", o, n_wr, e_wr); end
      checks++; if (last_alu !== e_alu) begin errors++; $display("FAIL alu_op op=%b got %b want %b", o, last_alu, e_alu); end
      model_retired = model_retired + 1;
      @(posedge clk); #1;
      mem_ready = 1'b0;
      checks++; if (retired_cnt !== model_retired) begin errors++; $display("FAIL retired_cnt got %0d want %0d", retired_cnt, model_retired); end
   endtask

   task automatic test_reset();
      rst = 1'b1; op = '0; zero = 1'b0; mem_ready = 1'b1;
      @(posedge clk); @(negedge clk); #1;
      checks++; if (state !== 4'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
      checks++; if ({mem_read, ir_write, pc_write, alu_src_b, instr_done} !== 6'b0) begin errors++; $display("FAIL reset_outputs got %b want 0", {mem_read, ir_write, pc_write, alu_src_b, instr_done}); end
      checks++; if (retired_cnt !== 32'd0 || mem_err !== 1'b0) begin errors++; $display("FAIL reset_counters got cnt=%0d err=%b want 0/0", retired_cnt, mem_err); end
      rst = 1'b0; mem_ready = 1'b0;
      model_retired = 0;
   endtask

   task automatic test_directed();
      run_instr(6'b001000, 1'b0, 0, 0);   // ADDI
      run_instr(6'b100011, 1'b0, 0, 3);   // LW with 3 wait cycles
      run_instr(6'b000100, 1'b1, 0, 0);   // BEQ taken
      run_instr(6'b000100, 1'b0, 1, 0);   // BEQ not taken
      run_instr(6'b000000, 1'b0, 2, 0);   // R-type
      run_instr(6'b101011, 1'b0, 0, 2);   // SW
      run_instr(6'b000010, 1'b0, 0, 0);   // J
   endtask

   task automatic test_wait_boundary();
      run_instr(6'b100011, 1'b0, WAIT_MAX - 1, WAIT_MAX - 1);
      run_instr(6'b101011, 1'b0, 0, WAIT_MAX - 1);
      checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL ack_at_limit mem_err got %b want 0", mem_err); end
   endtask

   task automatic test_random();
      logic [5:0] legal [9];
      logic [5:0] o;
      legal = '{6'b000000, 6'b001000, 6'b001010, 6'b001100, 6'b001101,
                6'b000100, 6'b100011, 6'b101011, 6'b000010};
      for (int i = 0; i < 40; i++) begin
         o = legal[$urandom_range(8)];
`ifndef ILLEGAL_OP_TRAP_EN
         if ($urandom_range(7) == 0) begin
            o = 6'($urandom);
            while (kind_of(o) != 6) o = 6'($urandom);
         end
`endif
         run_instr(o, 1'($urandom), $urandom_range(4), $urandom_range(5));
      end
   endtask

   task automatic test_illegal();
`ifdef ILLEGAL_OP_TRAP_EN
      int n_done;
      n_done = 0;
      op = 6'b111111; zero = 1'b0;
      @(negedge clk); mem_ready = 1'b1;
      @(negedge clk); mem_ready = 1'b0;
      repeat (5) begin
         @(negedge clk); #1;
         if (instr_done || mem_read || pc_write) n_done++;
      end
      checks++; if (state !== 4'd11) begin errors++; $display("FAIL trap_state got %0d want 11", state); end
      checks++; if (n_done !== 0) begin errors++; $display("FAIL trap_strobes got %0d want 0", n_done); end
      checks++; if (retired_cnt !== model_retired) begin errors++; $display("FAIL trap_retired got %0d want %0d", retired_cnt, model_retired); end
      do_reset();
`else
      run_instr(6'b111111, 1'b0, 0, 0);
      run_instr(6'b010001, 1'b1, 2, 0);
`endif
   endtask

   task automatic test_timeout();
      do_reset();
      op = 6'b001000;
      for (int i = 0; i < WAIT_MAX; i++) begin
         mem_ready = 1'b0;
         if (i == WAIT_MAX - 1) begin
            #1;
            checks++; if (state !== 4'd0 || mem_err !== 1'b0) begin errors++; $display("FAIL pre_limit got state=%0d err=%b want 0/0", state, mem_err); end
         end
         @(negedge clk);
      end
      #1;
      checks++; if (state !== 4'd12 || mem_err !== 1'b1) begin errors++; $display("FAIL timeout got state=%0d err=%b want 12/1", state, mem_err); end
      mem_ready = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      checks++; if (state !== 4'd12 || {mem_read, ir_write, pc_write, instr_done} !== 4'b0) begin errors++; $display("FAIL halt_hold got state=%0d strobes=%b want 12/0", state, {mem_read, ir_write, pc_write, instr_done}); end
      rst = 1'b1;
      @(posedge clk); #1;
      checks++; if (state !== 4'd0 || mem_err !== 1'b0 || retired_cnt !== 32'd0) begin errors++; $display("FAIL halt_reset got state=%0d err=%b cnt=%0d want 0/0/0", state, mem_err, retired_cnt); end
      @(negedge clk); rst = 1'b0; mem_ready = 1'b0; model_retired = 0;
   endtask

   task automatic test_rst_midwrite();
      int guard;
      logic seen, bad;
      run_instr(6'b000000, 1'b0, 0, 0);
      op = 6'b101011; guard = 0; seen = 1'b0;
      while (!seen && guard < 20) begin
         @(negedge clk);
         mem_ready = 1'b0; #1;
         if (mem_read) mem_ready = 1'b1;
         #1;
         if (mem_write) seen = 1'b1;
         guard++;
      end
      checks++; if (!seen) begin errors++; $display("FAIL reach_mem_wr got %0d cycles want mem_write", guard); end
      @(negedge clk);
      mem_ready = 1'b1; rst = 1'b1; #1;
      bad = mem_write | instr_done;
      @(posedge clk); #1;
      checks++; if (bad !== 1'b0) begin errors++; $display("FAIL rst_strobe got %b want 0", bad); end
      checks++; if (state !== 4'd0 || retired_cnt !== 32'd0) begin errors++; $display("FAIL rst_abort got state=%0d cnt=%0d want 0/0", state, retired_cnt); end
      @(negedge clk); rst = 1'b0; mem_ready = 1'b0; model_retired = 0;
      run_instr(6'b001101, 1'b0, 1, 0);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_wait_boundary();
      test_illegal();
      test_random();
      test_timeout();
      test_rst_midwrite();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
